pkt_byte_serializer: RTL

//  Store-and-forward egress stage directly downstream of the UDP/TCP/IP combine encoder.

---
 rtl/pkt_tx_pkg.sv | 29 ++
 rtl/pkt_sdp_ram.sv | 24 ++
 rtl/pkt_byte_serializer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_tx_pkg.sv
// Shared types for the packet byte serializer: FSM encoding, queue descriptor,
// and the ones'-complement adder used by the optional IPv4 header check.
package pkt_tx_pkg;

    localparam int unsigned IPV4_MIN_LEN = 20;
    // Descriptor fields are sized for the default 512-word buffer; smaller buffers use the low bits
    localparam int unsigned DESC_ADDR_W  = 9;
    localparam int unsigned DESC_WORDS_W = DESC_ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DROP  = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic [DESC_ADDR_W-1:0]  start;
        logic [DESC_WORDS_W-1:0] words;
        logic [15:0]             total_len;
    } pkt_desc_t;

    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + 16'(s[16]);
    endfunction

endpackage

// File: rtl/pkt_sdp_ram.sv
// Simple dual-port packet word RAM: one write port, one registered read port.
module pkt_sdp_ram #(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pkt_byte_serializer.sv
// Store-and-forward packet buffer replaying committed IPv4 packets as a byte stream.
// Optional header checksum screening on commit when IPV4_HDR_CHECK_EN is defined.
module pkt_byte_serializer
    import pkt_tx_pkg::*;
#(
    parameter int unsigned DEPTH_W = 512,
    parameter int unsigned PKT_Q   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pkg_data,
    input  logic        wr_en,
    input  logic        fin,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        buf_full,
    output logic        drop_pls
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_W);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned QA_W   = $clog2(PKT_Q);
    localparam int unsigned QC_W   = QA_W + 1;

    logic [ADDR_W-1:0] wr_ptr, pkt_start, rd_ptr, rd_ptr_d, ram_raddr_c, head_start;
    logic [CNT_W-1:0]  count, pkt_words, fin_words_c, free_words_c, drop_words_c;
    logic [15:0]       len_r, fin_len_c;
    logic              pkt_bad, wr_ok_c, fin_good_c, wr_drop_c, push_c, pop_c, hdr_bad_c;
    logic [31:0]       ram_rdata;

    pkt_desc_t         q_mem [PKT_Q];
    pkt_desc_t         head, desc_in;
    logic [QA_W-1:0]   q_head, q_tail;
    logic [QC_W-1:0]   q_cnt;
    logic              q_full, q_empty;

    tx_state_t         state, state_d;
    logic [31:0]       word_r, word_d;
    logic [1:0]        byte_sel, sel_d;
    logic [15:0]       byte_cnt, cnt_d;
    logic [7:0]        data_d;
    logic              valid_d, last_d, len_ok_c, len_fail_c;

    assign buf_full     = (count == CNT_W'(DEPTH_W));
    assign wr_ok_c      = wr_en && !buf_full;
    assign fin_words_c  = pkt_words + CNT_W'(wr_ok_c);
    assign fin_len_c    = (pkt_words == '0) ? pkg_data[15:0] : len_r;
    assign q_full       = (q_cnt == QC_W'(PKT_Q));
    assign q_empty      = (q_cnt == '0);
    assign fin_good_c   = !pkt_bad && !(wr_en && buf_full) && !hdr_bad_c &&
                          (fin_words_c != '0) && !q_full;
    assign push_c       = fin && fin_good_c;
    assign wr_drop_c    = fin && !fin_good_c;
    assign drop_words_c = wr_drop_c ? fin_words_c : '0;
    assign free_words_c = pop_c ? CNT_W'(head.words) : '0;
    assign head         = q_mem[q_head];
    assign head_start   = ADDR_W'(head.start);
    assign desc_in      = '{start: DESC_ADDR_W'(pkt_start), words: DESC_WORDS_W'(fin_words_c),
                            total_len: fin_len_c};

`ifdef IPV4_HDR_CHECK_EN
    logic [15:0] csum_r, csum_c;
    logic [3:0]  ihl_r, ihl_c;

    // Running sum covers only the first IHL words, including the word arriving with fin
    assign ihl_c     = (pkt_words == '0) ? pkg_data[27:24] : ihl_r;
    assign csum_c    = (wr_ok_c && (pkt_words < CNT_W'(ihl_c))) ?
                       ones_add(ones_add(csum_r, pkg_data[31:16]), pkg_data[15:0]) : csum_r;
    assign hdr_bad_c = (csum_c != 16'hFFFF) || (ihl_c < 4'd5) || (CNT_W'(ihl_c) > fin_words_c);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_r <= '0;
            ihl_r  <= '0;
        end else if (fin) begin
            csum_r <= '0;
            ihl_r  <= '0;
        end else begin
            csum_r <= csum_c;
            if (wr_ok_c && (pkt_words == '0)) begin
                ihl_r <= pkg_data[27:24];
            end
        end
    end
`else
    assign hdr_bad_c = 1'b0;
`endif

    // Write side: packet accumulation, commit or rollback on fin, occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            pkt_start <= '0;
            pkt_words <= '0;
            len_r     <= '0;
            pkt_bad   <= 1'b0;
            count     <= '0;
        end else begin
            if (wr_ok_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (wr_ok_c && (pkt_words == '0)) begin
                len_r <= pkg_data[15:0];
            end
            if (fin) begin
                pkt_words <= '0;
                pkt_bad   <= 1'b0;
                if (push_c) begin
                    pkt_start <= wr_ptr + ADDR_W'(wr_ok_c);
                end else begin
                    wr_ptr <= pkt_start;
                end
            end else begin
                if (wr_ok_c) begin
                    pkt_words <= pkt_words + CNT_W'(1);
                end
                if (wr_en && buf_full) begin
                    pkt_bad <= 1'b1;
                end
            end
            count <= count + CNT_W'(wr_ok_c) - free_words_c - drop_words_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_head <= '0;
            q_tail <= '0;
            q_cnt  <= '0;
        end else begin
            if (push_c) begin
                q_tail <= q_tail + QA_W'(1);
            end
            if (pop_c) begin
                q_head <= q_head + QA_W'(1);
            end
            q_cnt <= q_cnt + QC_W'(push_c) - QC_W'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            q_mem[q_tail] <= desc_in;
        end
    end

    pkt_sdp_ram #(
        .DEPTH  (DEPTH_W),
        .WIDTH  (32),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok_c),
        .wr_addr (wr_ptr),
        .wr_data (pkg_data),
        .rd_addr (ram_raddr_c),
        .rd_data (ram_rdata)
    );

    assign len_ok_c = (head.total_len >= 16'(IPV4_MIN_LEN)) &&
                      (18'(head.total_len) <= 18'({head.words, 2'b00}));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            word_r   <= '0;
            byte_sel <= '0;
            byte_cnt <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            drop_pls <= 1'b0;
        end else begin
            state    <= state_d;
            rd_ptr   <= rd_ptr_d;
            word_r   <= word_d;
            byte_sel <= sel_d;
            byte_cnt <= cnt_d;
            tx_data  <= data_d;
            tx_valid <= valid_d;
            tx_last  <= last_d;
            drop_pls <= wr_drop_c || len_fail_c;
        end
    end

    // Byte FSM: rd_ptr always addresses the word after the one held in word_r
    always_comb begin
        state_d     = state;
        rd_ptr_d    = rd_ptr;
        word_d      = word_r;
        sel_d       = byte_sel;
        cnt_d       = byte_cnt;
        data_d      = tx_data;
        valid_d     = tx_valid;
        last_d      = tx_last;
        pop_c       = 1'b0;
        len_fail_c  = 1'b0;
        ram_raddr_c = rd_ptr;
        case (state)
            IDLE: begin
                ram_raddr_c = head_start;
                if (!q_empty) begin
                    state_d  = FETCH;
                    rd_ptr_d = head_start + ADDR_W'(1);
                end
            end
            FETCH: begin
                if (len_ok_c) begin
                    state_d = SEND;
                    word_d  = ram_rdata;
                    data_d  = ram_rdata[31:24];
                    sel_d   = 2'd1;
                    cnt_d   = 16'd1;
                    valid_d = 1'b1;
                    last_d  = (head.total_len == 16'd1);
                end else begin
                    state_d    = DROP;
                    len_fail_c = 1'b1;
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    if (tx_last) begin
                        state_d = IDLE;
                        pop_c   = 1'b1;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = '0;
                    end else begin
                        cnt_d  = byte_cnt + 16'd1;
                        sel_d  = byte_sel + 2'd1;
                        last_d = (cnt_d == head.total_len);
                        case (byte_sel)
                            2'd0: begin
                                data_d   = ram_rdata[31:24];
                                word_d   = ram_rdata;
                                rd_ptr_d = rd_ptr + ADDR_W'(1);
                            end
                            2'd1:    data_d = word_r[23:16];
                            2'd2:    data_d = word_r[15:8];
                            default: data_d = word_r[7:0];
                        endcase
                    end
                end
            end
            DROP: begin
                pop_c   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
